// File: rtl/acc_differencer.sv
// Recovers addend, carry and signed overflow from an accumulator's running sum.
// Optional ACC_DIFF_OVFCNT_EN adds a saturating overflow-result counter.
module acc_differencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] S_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] A_o,
  output logic             C_o,
  output logic             V_o,
  output logic             valid_o,
`ifdef ACC_DIFF_OVFCNT_EN
  output logic [7:0]       ovf_cnt_o,
`endif
  input  logic             ready_i
);

  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] diff;
  logic             in_xfer;
  logic             out_xfer;
  logic             c_next;
  logic             v_next;

  assign ready_o  = !valid_o || ready_i;
  assign in_xfer  = valid_i && ready_o;
  assign out_xfer = valid_o && ready_i;

  // A coincident clear makes the incoming sample difference against zero
  assign base   = clr_i ? '0 : prev;
  assign diff   = S_i - base;
  assign c_next = S_i < base;
  assign v_next = (S_i[WIDTH-1] != base[WIDTH-1]) &&
                  (diff[WIDTH-1] != S_i[WIDTH-1]);

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      prev    <= '0;
      A_o     <= '0;
      C_o     <= 1'b0;
      V_o     <= 1'b0;
      valid_o <= 1'b0;
    end else if (in_xfer) begin
      prev    <= S_i;
      A_o     <= diff;
      C_o     <= c_next;
      V_o     <= v_next;
      valid_o <= 1'b1;
    end else if (clr_i) begin
      prev    <= '0;
      valid_o <= 1'b0;
    end else if (out_xfer) begin
      valid_o <= 1'b0;
    end
  end

`ifdef ACC_DIFF_OVFCNT_EN
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      ovf_cnt_o <= '0;
    end else if (clr_i) begin
      ovf_cnt_o <= '0;
    end else if (in_xfer && v_next && ovf_cnt_o != 8'hFF) begin
      ovf_cnt_o <= ovf_cnt_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_acc_differencer.sv
// Directed bench for acc_differencer: hand-computed vectors with
// immediate assertions at every check point.
module tb_acc_differencer;

  logic       clk_i;
  logic       rst;
  logic       clr_i;
  logic [7:0] S_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] A_o;
  logic       C_o;
  logic       V_o;
  logic       valid_o;
  logic       ready_i;
`ifdef ACC_DIFF_OVFCNT_EN
  logic [7:0] ovf_cnt_o;
`endif

  int nvec = 0;
  int nerr = 0;

  acc_differencer #(.WIDTH(8)) dut (
    .clk_i     (clk_i),
    .rst       (rst),
    .clr_i     (clr_i),
    .S_i       (S_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .A_o       (A_o),
    .C_o       (C_o),
    .V_o       (V_o),
    .valid_o   (valid_o),
`ifdef ACC_DIFF_OVFCNT_EN
    .ovf_cnt_o (ovf_cnt_o),
`endif
    .ready_i   (ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic res(input string tag, input logic [7:0] a,
                     input logic c, input logic v, input logic vld);
    chk({tag, ".A"}, {24'd0, A_o}, {24'd0, a});
    chk({tag, ".C"}, {31'd0, C_o}, {31'd0, c});
    chk({tag, ".V"}, {31'd0, V_o}, {31'd0, v});
    chk({tag, ".valid"}, {31'd0, valid_o}, {31'd0, vld});
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ovf(input string tag, input logic [7:0] exp);
`ifdef ACC_DIFF_OVFCNT_EN
    chk(tag, {24'd0, ovf_cnt_o}, {24'd0, exp});
`endif
  endtask

  initial begin
    rst = 1'b1; clr_i = 1'b0; S_i = 8'h00; valid_i = 1'b0; ready_i = 1'b1;
    #3;
    res("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rst.ready", {31'd0, ready_o}, 32'd1);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("post_rst.ready", {31'd0, ready_o}, 32'd1);
    ovf("rst.ovf", 8'd0);

    // first sample against zero
    S_i = 8'h05; valid_i = 1'b1;
    tick(); res("s05", 8'h05, 1'b0, 1'b0, 1'b1);
    S_i = 8'h7F;
    tick(); res("s7f", 8'h7A, 1'b0, 1'b0, 1'b1);
    S_i = 8'h80;
    tick(); res("s80", 8'h01, 1'b0, 1'b1, 1'b1);
    ovf("s80.ovf", 8'd1);
    S_i = 8'hF0;
    tick(); res("sf0", 8'h70, 1'b0, 1'b0, 1'b1);
    S_i = 8'h10;
    tick(); res("s10", 8'h20, 1'b1, 1'b0, 1'b1);
    S_i = 8'h10;
    tick(); res("eq", 8'h00, 1'b0, 1'b0, 1'b1);
    valid_i = 1'b0;
    tick(); chk("drain.valid", {31'd0, valid_o}, 32'd0);

    // backpressure with a held sample
    ready_i = 1'b0; valid_i = 1'b1; S_i = 8'h33;
    tick(); res("stall0", 8'h23, 1'b0, 1'b0, 1'b1);
    chk("stall0.ready", {31'd0, ready_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      res("stall", 8'h23, 1'b0, 1'b0, 1'b1);
      chk("stall.ready", {31'd0, ready_o}, 32'd0);
    end
    ready_i = 1'b1;
    #1;
    chk("unstall.ready", {31'd0, ready_o}, 32'd1);
    tick(); res("unstall", 8'h00, 1'b0, 1'b0, 1'b1);
    valid_i = 1'b0;
    tick(); chk("unstall.drain", {31'd0, valid_o}, 32'd0);

    // clear discards previous sample
    valid_i = 1'b1; S_i = 8'h40;
    tick(); res("s40", 8'h0D, 1'b0, 1'b0, 1'b1);
    valid_i = 1'b0; clr_i = 1'b1;
    tick(); chk("clr.valid", {31'd0, valid_o}, 32'd0);
    ovf("clr.ovf", 8'd0);
    clr_i = 1'b0; valid_i = 1'b1; S_i = 8'h41;
    tick(); res("s41", 8'h41, 1'b0, 1'b0, 1'b1);
    clr_i = 1'b1; S_i = 8'h85;
    tick(); res("clr_xfer", 8'h85, 1'b0, 1'b0, 1'b1);
    clr_i = 1'b0;

    // reset mid-transfer, then accumulator chain 0x10,0x70,0x90
    S_i = 8'h99;
    rst = 1'b1;
    #1;
    res("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rst_mid.ready", {31'd0, ready_o}, 32'd1);
    tick();
    rst = 1'b0;
    S_i = 8'h10;
    tick(); res("acc1", 8'h10, 1'b0, 1'b0, 1'b1);
    S_i = 8'h80;
    tick(); res("acc2", 8'h70, 1'b0, 1'b1, 1'b1);
    S_i = 8'h10;
    tick(); res("acc3", 8'h90, 1'b1, 1'b1, 1'b1);
    ovf("acc.ovf", 8'd2);
    S_i = 8'h20;
    #2;
    rst = 1'b1;
    #1;
    chk("acc_rst.valid", {31'd0, valid_o}, 32'd0);
    tick();
    rst = 1'b0;
    S_i = 8'h22;
    tick(); res("after_rst", 8'h22, 1'b0, 1'b0, 1'b1);
    valid_i = 1'b0;
    tick(); chk("end.valid", {31'd0, valid_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
